// File: rtl/four_bit_adder_if.sv
// Operand/result bundle for the registered 4-bit adder.
// The driver of a/b uses the master modport; the adder uses the slave modport.
interface four_bit_adder_if;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] s;
    logic       cout;

    modport master (
        output a,
        output b,
        input  s,
        input  cout
    );

    modport slave (
        input  a,
        input  b,
        output s,
        output cout
    );
endinterface

// File: rtl/four_bit_adder.sv
// Registered 4-bit ripple-carry adder. Define FOUR_BIT_ADDER_BCD_EN to present s as
// packed two-digit BCD; otherwise s is the 5-bit binary sum zero-extended to 8 bits.
module four_bit_adder (
    input  logic             clk,
    input  logic             rst,
    four_bit_adder_if.slave  bus
);

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic p;
        p = x ^ y;
        return {(x & y) | (ci & p), p ^ ci};
    endfunction

`ifdef FOUR_BIT_ADDER_BCD_EN
    // Compare-subtract split of 0..30 into tens (0..3) and ones (0..9).
    function automatic logic [7:0] to_bcd(input logic [4:0] val);
        logic [3:0] tens;
        logic [4:0] ones;
        if (val >= 5'd30) begin
            tens = 4'd3;
            ones = val - 5'd30;
        end else if (val >= 5'd20) begin
            tens = 4'd2;
            ones = val - 5'd20;
        end else if (val >= 5'd10) begin
            tens = 4'd1;
            ones = val - 5'd10;
        end else begin
            tens = 4'd0;
            ones = val;
        end
        return {tens, ones[3:0]};
    endfunction
`endif

    logic [4:0] carry_s;
    logic [3:0] sum_s;
    logic [1:0] fa_s;
    logic [4:0] raw_s;
    logic [7:0] result_s;
    logic [7:0] s_r;
    logic       cout_r;

    // Ripple-carry chain; carry into bit 0 is tied low.
    always_comb begin
        carry_s = 5'b00000;
        sum_s   = 4'b0000;
        fa_s    = 2'b00;
        for (int i = 0; i < 4; i++) begin
            fa_s           = full_add(bus.a[i], bus.b[i], carry_s[i]);
            sum_s[i]       = fa_s[0];
            carry_s[i + 1] = fa_s[1];
        end
        raw_s = {carry_s[4], sum_s};
    end

    // Output encoding of the raw 5-bit sum.
    always_comb begin
        result_s = 8'h00;
`ifdef FOUR_BIT_ADDER_BCD_EN
        result_s = to_bcd(raw_s);
`else
        result_s = {3'b000, raw_s};
`endif
    end

    // Result and carry registers; reset clears them without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_r    <= 8'h00;
            cout_r <= 1'b0;
        end else begin
            s_r    <= result_s;
            cout_r <= raw_s[4];
        end
    end

    assign bus.s    = s_r;
    assign bus.cout = cout_r;

endmodule

// File: tb/tb_four_bit_adder.sv
// Scoreboard bench for four_bit_adder: stimulus queues expected {s,cout} per edge,
// a monitor pops and compares one time unit after each rising edge.
module tb_four_bit_adder;

    logic clk;
    logic rst;
    four_bit_adder_if bus ();

    four_bit_adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks;
    int errors;
    logic [8:0] exp_q [$];
    int         tag_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer add, then divide/modulo split for BCD.
    function automatic logic [8:0] model(input int x, input int y);
        int t;
        logic [7:0] sv;
        t = x + y;
`ifdef FOUR_BIT_ADDER_BCD_EN
        sv = 8'((t / 10) * 16 + (t % 10));
`else
        sv = 8'(t);
`endif
        return {sv, (t > 15) ? 1'b1 : 1'b0};
    endfunction

    task automatic check_now(input string name, input logic [7:0] es, input logic ec);
        checks++;
        if (bus.s !== es || bus.cout !== ec) begin
            errors++;
            $display("FAIL %s s=%h cout=%b expected s=%h cout=%b", name, bus.s, bus.cout, es, ec);
        end
    endtask

    // Drive at the falling edge, queue the result due at the next rising edge.
    task automatic apply(input int x, input int y, input logic [8:0] e, input int tag);
        @(negedge clk);
        bus.a = 4'(x);
        bus.b = 4'(y);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Monitor.
    initial begin
        logic [8:0] e;
        int t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if (bus.s !== e[8:1] || bus.cout !== e[0]) begin
                    errors++;
                    $display("FAIL vec%0d s=%h cout=%b expected s=%h cout=%b",
                             t, bus.s, bus.cout, e[8:1], e[0]);
                end
            end
        end
    end

    // Directed vectors: a, b, binary s, BCD s, cout (hand computed).
    int         va [5] = '{0, 1, 7, 8, 15};
    int         vb [5] = '{1, 1, 5, 8, 15};
    logic [7:0] vsb[5] = '{8'h01, 8'h02, 8'h0C, 8'h10, 8'h1E};
    logic [7:0] vsd[5] = '{8'h01, 8'h02, 8'h12, 8'h16, 8'h30};
    logic       vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [7:0] es;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus.a  = 4'd5;
        bus.b  = 4'd9;

        // Asynchronous reset with arbitrary inputs, held over several edges.
        #2 rst = 1'b1;
        #1 check_now("reset_async", 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check_now("reset_hold", 8'h00, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
`ifdef FOUR_BIT_ADDER_BCD_EN
            es = vsd[i];
`else
            es = vsb[i];
`endif
            apply(va[i], vb[i], {es, vc[i]}, 100 + i);
        end

        // Two mid-cycle input changes; only the values at the edge count.
        @(negedge clk);
        bus.a = 4'd3;
        bus.b = 4'd4;
        #2 bus.a = 4'd9;
        #1 bus.b = 4'd6;
`ifdef FOUR_BIT_ADDER_BCD_EN
        exp_q.push_back({8'h15, 1'b0});
`else
        exp_q.push_back({8'h0F, 1'b0});
`endif
        tag_q.push_back(200);

        // Reset between edges clears at once; release loads the current sum.
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_now("reset_midstream", 8'h00, 1'b0);
        @(posedge clk);
        #1 check_now("reset_mid_hold", 8'h00, 1'b0);
        @(negedge clk);
        rst   = 1'b0;
        bus.a = 4'd12;
        bus.b = 4'd9;
`ifdef FOUR_BIT_ADDER_BCD_EN
        exp_q.push_back({8'h21, 1'b1});
`else
        exp_q.push_back({8'h15, 1'b1});
`endif
        tag_q.push_back(300);

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                apply(x, y, model(x, y), x * 16 + y);
            end
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
